lfsr_pn_gen: RTL and testbench

Parametrised pseudo-noise sequence generator. It succeeds the fixed 13-bit PN block in the display path. The block adds run-time register length, run-time polynomial, Fibonacci and Galois modes, seed load with lock-up detection, and optional period measurement. It sits between the debounced step/reset pulses and the output mask / BCD / seven-segment chain.

---
 rtl/lfsr_pkg.sv | 18 +
 rtl/lfsr_next.sv | 50 +++++
 rtl/lfsr_pn_gen.sv | 183 ++++++++++++++++++
 tb/tb_lfsr_pn_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared encodings and constants for the pseudo-noise generator.
package lfsr_pkg;

  // Feedback structure selected at load time
  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

  // Shortest register length the generator will run with
  localparam int MIN_LEN = 2;

  // Control state: IDLE until the first load, LOCKUP when an all-zero seed was loaded
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LOCKUP = 2'd2
  } lfsr_state_e;

endpackage

// File: rtl/lfsr_next.sv
// lfsr_next: combinational next-state function for Fibonacci and Galois LFSRs
// of run-time length len_eff (already clamped to MIN_LEN..WIDTH by the caller).
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] poly,
  input  logic [LEN_W-1:0] len_eff,
  input  logic             mode,
  output logic [WIDTH-1:0] next_state
);

  logic [WIDTH-1:0] lenmask_s;
  logic [WIDTH-1:0] shifted_s;
  logic             fb_s;
  logic             msb_s;

  // Active-length mask and the top active bit (the Galois output bit)
  always_comb begin
    lenmask_s = '0;
    msb_s     = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (LEN_W'(i) < len_eff) begin
        lenmask_s[i] = 1'b1;
      end else begin
        lenmask_s[i] = 1'b0;
      end
      if (LEN_W'(i + 1) == len_eff) begin
        msb_s = state[i];
      end else begin
        msb_s = msb_s;
      end
    end
  end

  // Shift left and apply the feedback of the selected structure
  always_comb begin
    shifted_s = {state[WIDTH-2:0], 1'b0};
    fb_s      = ^(state & poly);
    case (mode)
      MODE_FIB: next_state = (shifted_s | {{(WIDTH-1){1'b0}}, fb_s}) & lenmask_s;
      MODE_GAL: next_state = (shifted_s & lenmask_s) ^ (msb_s ? poly : {WIDTH{1'b0}});
      default:  next_state = '0;
    endcase
  end

endmodule

// File: rtl/lfsr_pn_gen.sv
// lfsr_pn_gen: run-time configurable pseudo-noise generator (length, taps,
// Fibonacci/Galois) with seed load, lock-up detection and registered masking.
// Optional feature macro: LFSR_PERIOD_EN enables the period measurement counter;
// without it period/period_valid are tied to 0.
module lfsr_pn_gen
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] poly,
  input  logic [LEN_W-1:0] len,
  input  logic             mode,
  input  logic             step,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] seq_out,
  output logic [WIDTH-1:0] masked_out,
  output logic             out_valid,
  output logic             lockup,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  lfsr_state_e      fsm_r;
  logic [WIDTH-1:0] state_r;
  logic [WIDTH-1:0] poly_r;
  logic [LEN_W-1:0] len_r;
  logic             mode_r;
  logic             out_valid_r;
  logic             lockup_r;
  logic [WIDTH-1:0] masked_r;

  logic [LEN_W-1:0] len_clamp_s;
  logic [WIDTH-1:0] in_mask_s;
  logic [WIDTH-1:0] seed_m_s;
  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] state_nxt_s;
  logic             step_acc_s;

  // Clamp the requested length and build the matching capture mask
  always_comb begin
    if (len < LEN_W'(MIN_LEN)) begin
      len_clamp_s = LEN_W'(MIN_LEN);
    end else if (len > LEN_W'(WIDTH)) begin
      len_clamp_s = LEN_W'(WIDTH);
    end else begin
      len_clamp_s = len;
    end
    in_mask_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (LEN_W'(i) < len_clamp_s) begin
        in_mask_s[i] = 1'b1;
      end else begin
        in_mask_s[i] = 1'b0;
      end
    end
  end

  assign seed_m_s   = seed & in_mask_s;
  // load has priority over step, so a colliding step is simply not accepted
  assign step_acc_s = (fsm_r == ST_ACTIVE) && step && !load;

  lfsr_next #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_next (
    .state      (state_r),
    .poly       (poly_r),
    .len_eff    (len_r),
    .mode       (mode_r),
    .next_state (next_s)
  );

  // Select what the state register holds after this edge
  always_comb begin
    if (load) begin
      state_nxt_s = seed_m_s;
    end else if (step_acc_s) begin
      state_nxt_s = next_s;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Configuration capture, state register, control FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r       <= ST_IDLE;
      state_r     <= '0;
      poly_r      <= '0;
      len_r       <= LEN_W'(MIN_LEN);
      mode_r      <= MODE_FIB;
      out_valid_r <= 1'b0;
      lockup_r    <= 1'b0;
      masked_r    <= '0;
    end else begin
      state_r  <= state_nxt_s;
      // masked output uses the current mask against the new state
      masked_r <= state_nxt_s & mask;
      if (load) begin
        poly_r      <= poly & in_mask_s;
        len_r       <= len_clamp_s;
        mode_r      <= mode;
        out_valid_r <= 1'b0;
        if (seed_m_s == {WIDTH{1'b0}}) begin
          fsm_r    <= ST_LOCKUP;
          lockup_r <= 1'b1;
        end else begin
          fsm_r    <= ST_ACTIVE;
          lockup_r <= 1'b0;
        end
      end else begin
        case (fsm_r)
          ST_ACTIVE: out_valid_r <= step;
          ST_IDLE:   out_valid_r <= 1'b0;
          ST_LOCKUP: out_valid_r <= 1'b0;
          default: begin
            fsm_r       <= ST_IDLE;
            out_valid_r <= 1'b0;
            lockup_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign seq_out    = state_r;
  assign masked_out = masked_r;
  assign out_valid  = out_valid_r;
  assign lockup     = lockup_r;

`ifdef LFSR_PERIOD_EN
  logic [WIDTH-1:0] seed_r;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] period_r;
  logic             period_valid_r;
  logic [WIDTH-1:0] cnt_inc_s;

  // Saturating increment: the counter sticks at all-ones
  always_comb begin
    if (&cnt_r) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Count accepted steps and latch the count when the sequence returns to its seed
  always_ff @(posedge clk) begin
    if (rst) begin
      seed_r         <= '0;
      cnt_r          <= '0;
      period_r       <= '0;
      period_valid_r <= 1'b0;
    end else if (load) begin
      seed_r         <= seed_m_s;
      cnt_r          <= '0;
      period_valid_r <= 1'b0;
    end else if (step_acc_s) begin
      if (next_s == seed_r) begin
        period_r       <= cnt_inc_s;
        period_valid_r <= 1'b1;
        cnt_r          <= '0;
      end else begin
        cnt_r          <= cnt_inc_s;
      end
    end else begin
      cnt_r          <= cnt_r;
    end
  end

  assign period       = period_r;
  assign period_valid = period_valid_r;
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_pn_gen.sv
// tb_lfsr_pn_gen: directed test-plan cases plus randomized traffic, checked
// against a behavioural model computed from the sequence rules on integers.
module tb_lfsr_pn_gen;

  localparam int WIDTH = 16;
  localparam int LEN_W = 5;
`ifdef LFSR_PERIOD_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, load, mode, step;
  logic [WIDTH-1:0] seed, poly, mask;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] seq_out, masked_out, period;
  logic out_valid, lockup, period_valid;

  int n_chk  = 0;
  int n_pass = 0;

  // behavioural model state
  int unsigned m_state, m_seed, m_poly, m_len, m_mode, m_fsm;
  int unsigned m_cnt, m_period, m_pv, m_ov, m_lock, m_masked;

  int unsigned fib_exp [15] = '{32'h3, 32'h7, 32'hF, 32'hE, 32'hD, 32'hA, 32'h5, 32'hB,
                                32'h6, 32'hC, 32'h9, 32'h2, 32'h4, 32'h8, 32'h1};
  int unsigned gal_exp [4]  = '{32'h2, 32'h4, 32'h8, 32'h3};

  always #5 clk = ~clk;

  lfsr_pn_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .seed         (seed),
    .poly         (poly),
    .len          (len),
    .mode         (mode),
    .step         (step),
    .mask         (mask),
    .seq_out      (seq_out),
    .masked_out   (masked_out),
    .out_valid    (out_valid),
    .lockup       (lockup),
    .period       (period),
    .period_valid (period_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int unsigned lenmask(input int unsigned l);
    return (32'd1 << l) - 32'd1;
  endfunction

  function automatic int unsigned ref_next(input int unsigned s);
    int unsigned lm;
    int unsigned fb;
    int unsigned o;
    lm = lenmask(m_len);
    if (m_mode == 0) begin
      fb = $countones(s & m_poly) % 2;
      return ((s << 1) | fb) & lm;
    end
    o = (s >> (m_len - 1)) & 32'd1;
    return ((s << 1) & lm) ^ ((o != 0) ? m_poly : 32'd0);
  endfunction

  // advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    int unsigned l, nx, inc;
    bit acc;
    if (rst) begin
      m_state = 0; m_seed = 0; m_poly = 0; m_len = 2; m_mode = 0; m_fsm = 0;
      m_cnt = 0; m_period = 0; m_pv = 0; m_ov = 0; m_lock = 0; m_masked = 0;
    end else begin
      acc = (m_fsm == 1) && step && !load;
      if (load) begin
        l = (len < 2) ? 2 : ((len > WIDTH) ? WIDTH : 32'(len));
        m_len   = l;
        m_state = 32'(seed) & lenmask(l);
        m_poly  = 32'(poly) & lenmask(l);
        m_mode  = 32'(mode);
        m_fsm   = (m_state != 0) ? 1 : 2;
        m_lock  = (m_state == 0) ? 1 : 0;
        m_ov    = 0;
        m_seed  = m_state;
        m_cnt   = 0;
        m_pv    = 0;
      end else if (acc) begin
        nx = ref_next(m_state);
        m_state = nx;
        m_ov = 1;
        inc = (m_cnt >= 32'hFFFF) ? m_cnt : m_cnt + 1;
        if (nx == m_seed) begin
          m_period = inc; m_pv = 1; m_cnt = 0;
        end else begin
          m_cnt = inc;
        end
      end else begin
        m_ov = 0;
      end
      m_masked = m_state & 32'(mask);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("seq_out",      32'(seq_out),      m_state);
    check("masked_out",   32'(masked_out),   m_masked);
    check("out_valid",    32'(out_valid),    m_ov);
    check("lockup",       32'(lockup),       m_lock);
    check("period",       32'(period),       PEN ? m_period : 32'd0);
    check("period_valid", 32'(period_valid), PEN ? m_pv : 32'd0);
  endtask

  task automatic do_load(input logic [15:0] s, input logic [15:0] p,
                         input logic [4:0] l, input logic md);
    load = 1'b1; step = 1'b0; seed = s; poly = p; len = l; mode = md;
    tick();
    load = 1'b0;
  endtask

  task automatic do_steps(input int n);
    step = 1'b1;
    repeat (n) tick();
    step = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; step = 1'b0; seed = '0; poly = '0; len = '0;
    mode = 1'b0; mask = 16'hFFFF;
    tick(); tick();
    check("rst_seq", 32'(seq_out), 32'd0);
    check("rst_lockup", 32'(lockup), 32'd0);
    rst = 1'b0;
    // IDLE ignores step
    do_steps(3);
    check("idle_seq", 32'(seq_out), 32'd0);

    // Fibonacci, len 4, poly 0x9
    do_load(16'h0001, 16'h0009, 5'd4, 1'b0);
    step = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("fib_seq", 32'(seq_out), fib_exp[i]);
    end
    step = 1'b0;
    check("fib_period", 32'(period), PEN ? 32'd15 : 32'd0);
    check("fib_pvalid", 32'(period_valid), PEN ? 32'd1 : 32'd0);

    // Galois, len 4, poly 0x3, with a partial mask
    mask = 16'h000A;
    do_load(16'h0001, 16'h0003, 5'd4, 1'b1);
    step = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("gal_seq", 32'(seq_out), gal_exp[i]);
      check("gal_ovalid", 32'(out_valid), 32'd1);
    end
    step = 1'b0;
    tick();
    check("gal_ovalid_end", 32'(out_valid), 32'd0);
    mask = 16'hFFFF;

    // Seed masks to zero -> lockup, steps ignored
    do_load(16'h0010, 16'h0009, 5'd4, 1'b0);
    check("lock_set", 32'(lockup), 32'd1);
    do_steps(3);
    check("lock_seq", 32'(seq_out), 32'd0);
    do_load(16'h0001, 16'h0009, 5'd4, 1'b0);
    check("lock_clr", 32'(lockup), 32'd0);

    // load and step in the same cycle
    load = 1'b1; step = 1'b1; seed = 16'h0005; poly = 16'h0009; len = 5'd4; mode = 1'b0;
    tick();
    load = 1'b0; step = 1'b0;
    check("coll_seq", 32'(seq_out), 32'h5);
    check("coll_ovalid", 32'(out_valid), 32'd0);

    // length clamping
    do_load(16'hFFFF, 16'h0003, 5'd1, 1'b0);
    check("len1_seq", 32'(seq_out), 32'h3);
    do_steps(4);
    do_load(16'hFFFF, 16'hB400, 5'd31, 1'b0);
    check("len31_seq", 32'(seq_out), 32'hFFFF);
    do_steps(4);

    // reset mid-run together with step
    step = 1'b1; rst = 1'b1;
    tick();
    check("rstmid_seq", 32'(seq_out), 32'd0);
    check("rstmid_ovalid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    do_steps(3);
    check("rstmid_idle", 32'(seq_out), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 15) == 0);
      step = ($urandom_range(0, 3) != 0);
      seed = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 31)) : 16'($urandom);
      poly = 16'($urandom);
      len  = 5'($urandom_range(0, 31));
      mode = 1'($urandom);
      if ($urandom_range(0, 7) == 0) mask = 16'($urandom);
      tick();
    end
    rst = 1'b0; load = 1'b0; step = 1'b0; mask = 16'hFFFF;

    // full 16-bit maximal-length period
    do_load(16'hACE1, 16'hB400, 5'd16, 1'b0);
    do_steps(65535);
    check("max_seq", 32'(seq_out), 32'hACE1);
    check("max_period", 32'(period), PEN ? 32'd65535 : 32'd0);
    check("max_pvalid", 32'(period_valid), PEN ? 32'd1 : 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
